// File: rtl/score_digits_if.sv
// rtl/score_digits_if.sv - point/restart inputs and display/score outputs of the scoreboard
interface score_digits_if;
  logic       point_l;
  logic       point_r;
  logic       new_game;
  logic [1:0] tog;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic       game_over;
  logic       winner;

  modport master (
    output point_l, point_r, new_game,
    input  tog, dig0, dig1, dig2, dig3, game_over, winner
  );

  modport slave (
    input  point_l, point_r, new_game,
    output tog, dig0, dig1, dig2, dig3, game_over, winner
  );
endinterface

// File: rtl/score_digits.sv
// rtl/score_digits.sv - two-player BCD score keeper with win detection and digit scan select
module score_digits #(
  parameter int REFRESH_DIV = 100000,
  parameter int WIN_SCORE   = 11
) (
  input logic         clk,
  input logic         reset,
  score_digits_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]    WIN_VAL    = 7'(WIN_SCORE);

  typedef enum logic {PLAY, OVER} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    tog;
  logic          prev_l, prev_r;
  logic [7:0]    l_score, r_score;
  logic          game_over, winner;

  logic          rise_l, rise_r;
  logic [7:0]    l_inc, r_inc;
  logic          l_wins, r_wins;

  // Score held as {tens, ones}; saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] n;
    n = s;
    if (s[3:0] != 4'd9) begin
      n[3:0] = s[3:0] + 4'd1;
    end else if (s[7:4] != 4'd9) begin
      n[3:0] = 4'd0;
      n[7:4] = s[7:4] + 4'd1;
    end
    return n;
  endfunction

  function automatic logic is_win(input logic [7:0] s);
    logic [6:0] v;
    v = 7'(s[7:4]) * 7'd10 + 7'(s[3:0]);
    return v == WIN_VAL;
  endfunction

  always_comb begin
    rise_l = bus.point_l & ~prev_l;
    rise_r = bus.point_r & ~prev_r;
    l_inc  = bcd_inc(l_score);
    r_inc  = bcd_inc(r_score);
    l_wins = rise_l && is_win(l_inc);
    r_wins = rise_r && is_win(r_inc);
  end

  // Scan prescaler runs free of game state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      tog   <= 2'd0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      tog   <= tog + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PLAY;
      prev_l    <= 1'b0;
      prev_r    <= 1'b0;
      l_score   <= 8'h00;
      r_score   <= 8'h00;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      prev_l <= bus.point_l;
      prev_r <= bus.point_r;
      case (state)
        PLAY: begin
          if (bus.new_game) begin
            l_score <= 8'h00;
            r_score <= 8'h00;
          end else begin
            if (rise_l) l_score <= l_inc;
            if (rise_r) r_score <= r_inc;
            // Left takes priority on a simultaneous win.
            if (l_wins) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else if (r_wins) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end
          end
        end
        OVER: begin
          if (bus.new_game) begin
            l_score   <= 8'h00;
            r_score   <= 8'h00;
            winner    <= 1'b0;
            game_over <= 1'b0;
            state     <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign bus.tog       = tog;
  assign bus.dig0      = l_score[3:0];
  assign bus.dig1      = l_score[7:4];
  assign bus.dig2      = r_score[3:0];
  assign bus.dig3      = r_score[7:4];
  assign bus.game_over = game_over;
  assign bus.winner    = winner;

endmodule

// File: tb/tb_score_digits.sv
// tb/tb_score_digits.sv - scoreboard bench for score_digits with REFRESH_DIV=4, WIN_SCORE=11
module tb_score_digits;
  localparam int DIV = 4;
  localparam int WIN = 11;

  logic clk;
  logic reset;

  score_digits_if bus ();

  score_digits #(.REFRESH_DIV(DIV), .WIN_SCORE(WIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] tog;
    logic [3:0] d0, d1, d2, d3;
    logic       go, win;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int ls, rs, cyc;
  bit over, wnr, pl_prev, pr_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.tog = 2'((cyc / DIV) % 4);
    e.d0  = 4'(ls % 10);
    e.d1  = 4'(ls / 10);
    e.d2  = 4'(rs % 10);
    e.d3  = 4'(rs / 10);
    e.go  = over;
    e.win = wnr;
    return e;
  endfunction

  task automatic model_reset();
    ls = 0; rs = 0; cyc = 0;
    over = 0; wnr = 0; pl_prev = 0; pr_prev = 0;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, ".tog"},  32'(bus.tog),       32'(e.tog));
    chk({tag, ".dig0"}, 32'(bus.dig0),      32'(e.d0));
    chk({tag, ".dig1"}, 32'(bus.dig1),      32'(e.d1));
    chk({tag, ".dig2"}, 32'(bus.dig2),      32'(e.d2));
    chk({tag, ".dig3"}, 32'(bus.dig3),      32'(e.d3));
    chk({tag, ".over"}, 32'(bus.game_over), 32'(e.go));
    chk({tag, ".win"},  32'(bus.winner),    32'(e.win));
  endtask

  // Called at posedge+1: drives inputs, advances the model, checks after the next edge.
  task automatic step(input logic pl, input logic pr, input logic ng, input string tag);
    bit rl, rr;
    bus.point_l  = pl;
    bus.point_r  = pr;
    bus.new_game = ng;
    rl = pl && !pl_prev;
    rr = pr && !pr_prev;
    pl_prev = pl;
    pr_prev = pr;
    if (!over) begin
      if (ng) begin
        ls = 0; rs = 0;
      end else begin
        if (rl && ls < 99) ls++;
        if (rr && rs < 99) rs++;
        if (rl && ls == WIN) begin
          over = 1; wnr = 0;
        end else if (rr && rs == WIN) begin
          over = 1; wnr = 1;
        end
      end
    end else if (ng) begin
      ls = 0; rs = 0; over = 0; wnr = 0;
    end
    cyc++;
    q.push_back(snapshot());
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    reset        = 1'b0;
    bus.point_l  = 1'b0;
    bus.point_r  = 1'b0;
    bus.new_game = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    q.push_back(snapshot());
    compare_out("reset");
    reset = 1'b1;

    for (int i = 0; i < 16; i++) step(0, 0, 0, "scan");

    for (int i = 0; i < 20; i++) step(0, 1, 0, "hold_r");
    step(0, 0, 0, "hold_r_rel");

    for (int i = 0; i < 11; i++) begin
      step(1, 0, 0, "l_pulse");
      step(0, 0, 0, "l_gap");
    end

    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, "r_in_over");
      step(0, 0, 0, "r_in_over_gap");
    end
    step(0, 0, 1, "ng_over");
    step(0, 0, 0, "ng_over_after");

    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, "both_pulse");
      step(0, 0, 0, "both_gap");
    end
    step(1, 1, 0, "tie_win");
    step(0, 0, 0, "tie_after");

    step(1, 0, 0, "held_over");
    step(1, 0, 1, "held_ng");
    step(1, 0, 0, "held_play");
    step(0, 0, 0, "held_rel");

    for (int i = 0; i < 11; i++) begin
      step(0, 1, 0, "r_win_pulse");
      step(0, 0, 0, "r_win_gap");
    end
    step(0, 0, 1, "ng_r_over");

    for (int i = 0; i < 5; i++) begin
      step(1, i < 3, 0, "to_5_3");
      step(0, 0, 0, "to_5_3_gap");
    end
    step(1, 0, 1, "ng_with_point");
    step(0, 0, 0, "ng_with_point_after");

    for (int i = 0; i < 9; i++) begin
      step(i < 7, 1, 0, "to_7_9");
      step(0, 0, 0, "to_7_9_gap");
    end
    step(0, 0, 0, "pre_rst");

    #2;
    reset = 1'b0;
    #1;
    model_reset();
    q.push_back(snapshot());
    compare_out("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    q.push_back(snapshot());
    compare_out("rst_held");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step(0, 0, 0, "post_rst_scan");

    if (q.size() != 0) chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_digits.md
# score_digits

Score keeper and display scan source for the Pong scoreboard. Counts points for the left and right players as two-digit BCD values and detects the winning score. Generates the 2-bit digit-select sequence `tog` and the four digit nibbles `dig0..dig3` consumed by the 7-segment display driver, which maps tog 0→dig2, 1→dig3, 2→dig0, 3→dig1.

## Interface
- `REFRESH_DIV`, 100000: clocks per display digit slot; legal range ≥1.
- `WIN_SCORE`, 11: winning point total; legal range 1..99.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `point_l`  in  1  left player scored; synchronous to `clk`; rising edge counts.
- `point_r`  in  1  right player scored; synchronous to `clk`; rising edge counts.
- `new_game`  in  1  synchronous restart request; level sampled each clock.
- `tog`  out  2  display digit select; registered.
- `dig0`  out  4  left score ones, BCD.
- `dig1`  out  4  left score tens, BCD.
- `dig2`  out  4  right score ones, BCD.
- `dig3`  out  4  right score tens, BCD.
- `game_over`  out  1  high while in state OVER.
- `winner`  out  1  0 = left, 1 = right; meaningful only while `game_over`=1.

## Operation
- Reset (`reset`=0): all outputs 0. Prescaler 0, edge-detect history 0, state PLAY.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. On the terminal count, `tog` increments mod 4 (3→0).
  - With REFRESH_DIV=1, `tog` advances every clock.
  - Prescaler and `tog` are never affected by `new_game`, points, or state.
- Edge detect: `prev_l`/`prev_r` register the inputs each clock. `rise_x` = `point_x` & ~`prev_x`. A held-high input counts exactly once.
- BCD increment, per player: if ones<9, ones+1. Otherwise ones=0 and tens+1. At 99 the score saturates; this is unreachable for legal `WIN_SCORE`.
- FSM with states PLAY and OVER:
  - PLAY, `new_game`=1: both scores cleared to 00, stay PLAY. Point edges in the same cycle are dropped.
  - PLAY, point edge(s): the corresponding score(s) increment on that edge.
    - If a post-increment score equals `WIN_SCORE`, go to OVER on the same edge and set `winner`.
    - Both players may increment in the same cycle. If both reach `WIN_SCORE` simultaneously, `winner`=0 (left priority).
  - OVER: point edges ignored and scores frozen. Edge history still updates, so an input held across restart does not count.
  - OVER, `new_game`=1: scores cleared to 00, `winner`=0, go to PLAY.
- `game_over` = (state==OVER), registered.
- Winning is compared as decimal value: tens×10 + ones == `WIN_SCORE`. The tens×10 term is a constant-width multiply-by-ten, or an equivalent precomputed BCD compare.

## Timing
- Point latency: `point_x` sampled high at edge N with `prev_x`=0 → updated `digX` visible after edge N (1 clock).
- `game_over`/`winner` update at the same edge N as the winning increment.
- `new_game` sampled at edge N → digits 0 and `game_over`=0 after edge N.
- `tog` period: 4×REFRESH_DIV clocks. Each value is held REFRESH_DIV clocks.
- Reset assertion clears immediately (asynchronous). Deassertion is synchronous to the next edge; the first `tog` step occurs REFRESH_DIV clocks after release.
- Reset mid-game or mid-scan: everything returns to reset values and no point is retained.

## Test plan
- REFRESH_DIV=4, after reset → `tog` sequence 0,0,0,0,1,1,1,1,2…,3,3,3,3,0; digits all 0; `game_over`=0.
- Pulse `point_l` 10 times (1-clock pulses, gaps) → `dig1`=1, `dig0`=0 after the 10th. One more pulse → score 11, `game_over`=1, `winner`=0 on that edge.
- Hold `point_r` high for 20 clocks → `dig2`=1 only. Pulse `point_r` in OVER → no change.
- Left at 10, right at 10, `point_l` and `point_r` rise in the same clock → both show 11, `game_over`=1, `winner`=0.
- `new_game` together with a `point_l` edge in PLAY at score 5–3 → scores 00, no increment. `new_game` in OVER → `game_over`=0, `winner`=0.
- Assert `reset` low mid-prescale with scores 7–9 → all outputs 0 immediately. After release, `tog` holds 0 for exactly REFRESH_DIV clocks.
